// File: rtl/sop_pkg.sv
// Shared types and constants for the sum-of-products feeder: widths, coefficient
// count, coefficient index type and the feeder FSM state encoding.
package sop_pkg;

    localparam int SOP_WIDTH      = 4;
    localparam int SOP_NUM_COEF   = 4;
    localparam int SOP_FIFO_DEPTH = 4;

    typedef logic [1:0] coef_idx_t;

    typedef enum logic [1:0] {
        UNCFG       = 2'd0,
        RUN         = 2'd1,
        COMMIT_WAIT = 2'd2
    } sop_state_t;

endpackage : sop_pkg

// File: rtl/sop_stream_feeder_if.sv
// Sample-in / tuple-out handshake bundle of the feeder. The master side is the
// feeder itself; the slave side is its environment (source and SOP stage).
interface sop_stream_feeder_if
    import sop_pkg::*;
#(
    parameter int WIDTH = SOP_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] DATA_IN;
    logic [WIDTH-1:0] C0;
    logic [WIDTH-1:0] C1;
    logic [WIDTH-1:0] C2;
    logic [WIDTH-1:0] C3;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        input  out_ready,
        output DATA_IN,
        output C0,
        output C1,
        output C2,
        output C3
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  DATA_IN,
        input  C0,
        input  C1,
        input  C2,
        input  C3
    );

endinterface : sop_stream_feeder_if

// File: rtl/sop_sample_fifo.sv
// Synchronous sample FIFO with occupancy counter; FIFO_DEPTH must be a power of 2.
// Push is ignored when full, pop is ignored when empty.
module sop_sample_fifo #(
    parameter int WIDTH      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Storage carries data only, so it is left out of reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule : sop_sample_fifo

// File: rtl/sop_stream_feeder.sv
// Feeder for the sum-of-products stage: sample FIFO, shadow/active coefficient
// banks and a tuple output register. Optional handshake counter: SOP_FEEDER_CNT_EN.
module sop_stream_feeder
    import sop_pkg::*;
#(
    parameter int WIDTH      = SOP_WIDTH,
    parameter int FIFO_DEPTH = SOP_FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coef_wr_en,
    input  coef_idx_t           coef_addr,
    input  logic [WIDTH-1:0]    coef_wdata,
    input  logic                coef_commit,
    sop_stream_feeder_if.master bus,
    output logic                configured
`ifdef SOP_FEEDER_CNT_EN
    ,
    output logic [15:0]         tuple_cnt
`endif
);

    sop_state_t       state;
    logic             commit_pending;
    logic [WIDTH-1:0] shadow [SOP_NUM_COEF];
    logic [WIDTH-1:0] active [SOP_NUM_COEF];

    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_head;
    logic             pop_p0;
    logic             out_free_p0;

    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;
    logic [WIDTH-1:0] coef_p1 [SOP_NUM_COEF];

    sop_sample_fifo #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.in_valid),
        .push_data (bus.in_data),
        .pop       (pop_p0),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.in_ready = !fifo_full;
    assign out_free_p0  = !vld_p1 || bus.out_ready;
    assign pop_p0       = (state == RUN) && out_free_p0 && !fifo_empty;

    // Shadow bank: software-facing, never read by the datapath directly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SOP_NUM_COEF; i++) begin
                shadow[i] <= '0;
            end
        end else if (coef_wr_en) begin
            shadow[coef_addr] <= coef_wdata;
        end
    end

    // ---- stage p0 -> p1: FSM, active bank and tuple output register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= UNCFG;
            configured     <= 1'b0;
            commit_pending <= 1'b0;
            vld_p1         <= 1'b0;
            data_p1        <= '0;
            for (int i = 0; i < SOP_NUM_COEF; i++) begin
                active[i]  <= '0;
                coef_p1[i] <= '0;
            end
        end else begin
            case (state)
                UNCFG: begin
                    if (coef_commit) begin
                        for (int i = 0; i < SOP_NUM_COEF; i++) begin
                            active[i] <= shadow[i];
                        end
                        configured <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (out_free_p0) begin
                        if (!fifo_empty) begin
                            vld_p1  <= 1'b1;
                            data_p1 <= fifo_head;
                            for (int i = 0; i < SOP_NUM_COEF; i++) begin
                                coef_p1[i] <= active[i];
                            end
                        end else begin
                            vld_p1 <= 1'b0;
                        end
                    end
                    if (coef_commit) begin
                        commit_pending <= 1'b1;
                        state          <= COMMIT_WAIT;
                    end
                end
                COMMIT_WAIT: begin
                    // Bank swap only once the held tuple is gone; no pop on this edge
                    if (commit_pending && out_free_p0) begin
                        for (int i = 0; i < SOP_NUM_COEF; i++) begin
                            active[i] <= shadow[i];
                        end
                        commit_pending <= 1'b0;
                        vld_p1         <= 1'b0;
                        state          <= RUN;
                    end
                end
                default: begin
                    state <= UNCFG;
                end
            endcase
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.DATA_IN   = data_p1;
    assign bus.C0        = coef_p1[0];
    assign bus.C1        = coef_p1[1];
    assign bus.C2        = coef_p1[2];
    assign bus.C3        = coef_p1[3];

`ifdef SOP_FEEDER_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tuple_cnt <= '0;
        end else if (vld_p1 && bus.out_ready) begin
            tuple_cnt <= sat_inc(tuple_cnt);
        end
    end
`endif

endmodule : sop_stream_feeder

// File: tb/tb_sop_stream_feeder.sv
// Scoreboard bench for sop_stream_feeder: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_sop_stream_feeder;

    localparam int W     = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coef_wr_en = 1'b0;
    logic [1:0] coef_addr = 2'd0;
    logic [3:0] coef_wdata = 4'd0;
    logic       coef_commit = 1'b0;
    logic       configured;
`ifdef SOP_FEEDER_CNT_EN
    logic [15:0] tuple_cnt;
`endif

    sop_stream_feeder_if #(.WIDTH(W)) bus ();

    sop_stream_feeder #(.WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .coef_wr_en  (coef_wr_en),
        .coef_addr   (coef_addr),
        .coef_wdata  (coef_wdata),
        .coef_commit (coef_commit),
        .bus         (bus),
        .configured  (configured)
`ifdef SOP_FEEDER_CNT_EN
        ,
        .tuple_cnt   (tuple_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: sample queue, banks, and the tuples the DUT owes downstream
    logic [3:0]  m_q[$];
    logic [19:0] sb[$];
    logic [3:0]  m_shadow[4];
    logic [3:0]  m_active[4];
    bit          m_cfg;
    bit          m_pending;
    bit          m_vld;
    int          m_hs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = 4'd0;
            m_active[i] = 4'd0;
        end
        m_cfg = 0;
        m_pending = 0;
        m_vld = 0;
        m_hs = 0;
    endfunction

    // One clock edge worth of behaviour, using the inputs held across that edge
    function automatic void model_step();
        bit free;
        bit room;
        logic [3:0] s;
        free = !m_vld || bus.out_ready;
        room = m_q.size() < DEPTH;
        if (m_vld && bus.out_ready && m_hs < 65535) m_hs++;
        if (!m_cfg) begin
            if (coef_commit) begin
                m_active = m_shadow;
                m_cfg = 1;
            end
        end else if (m_pending) begin
            if (free) begin
                m_active = m_shadow;
                m_pending = 0;
                m_vld = 0;
            end
        end else begin
            if (free) begin
                if (m_q.size() > 0) begin
                    s = m_q.pop_front();
                    sb.push_back({s, m_active[0], m_active[1], m_active[2], m_active[3]});
                    m_vld = 1;
                end else begin
                    m_vld = 0;
                end
            end
            if (coef_commit) m_pending = 1;
        end
        if (bus.in_valid && room) m_q.push_back(bus.in_data);
        if (coef_wr_en) m_shadow[coef_addr] = coef_wdata;
    endfunction

    // Monitor: compares the presented tuple and status against the model
    always @(negedge clk) begin
        chk("out_valid", 32'(bus.out_valid), 32'(m_vld));
        chk("in_ready", 32'(bus.in_ready), 32'(m_q.size() < DEPTH));
        chk("configured", 32'(configured), 32'(m_cfg));
`ifdef SOP_FEEDER_CNT_EN
        chk("tuple_cnt", 32'(tuple_cnt), 32'(m_hs));
`endif
        if (m_vld) begin
            if (sb.size() == 0) begin
                chk("scoreboard_nonempty", 32'(sb.size()), 32'd1);
            end else begin
                chk("tuple", 32'({bus.DATA_IN, bus.C0, bus.C1, bus.C2, bus.C3}), 32'(sb[0]));
                if (bus.out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic cycle(input bit iv, input logic [3:0] id, input bit ordy,
                         input bit we = 0, input logic [1:0] a = 2'd0,
                         input logic [3:0] wd = 4'd0, input bit cm = 0);
        bus.in_valid = iv;
        bus.in_data  = id;
        bus.out_ready = ordy;
        coef_wr_en   = we;
        coef_addr    = a;
        coef_wdata   = wd;
        coef_commit  = cm;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_tuple(input string name, input logic [3:0] d,
                               input logic [3:0] c0, input logic [3:0] c1,
                               input logic [3:0] c2, input logic [3:0] c3);
        chk(name, 32'({bus.DATA_IN, bus.C0, bus.C1, bus.C2, bus.C3}), 32'({d, c0, c1, c2, c3}));
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge
    task automatic apply_reset();
        bus.in_valid = 0;
        bus.in_data = 0;
        bus.out_ready = 0;
        coef_wr_en = 0;
        coef_commit = 0;
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_configured", 32'(configured), 32'd0);
        check_tuple("rst_tuple", 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic write_shadow(input logic [3:0] c0, input logic [3:0] c1,
                                input logic [3:0] c2, input logic [3:0] c3, input bit ordy);
        cycle(0, 0, ordy, 1, 2'd0, c0);
        cycle(0, 0, ordy, 1, 2'd1, c1);
        cycle(0, 0, ordy, 1, 2'd2, c2);
        cycle(0, 0, ordy, 1, 2'd3, c3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 0;
        bus.in_data = 0;
        bus.out_ready = 0;
        model_reset();
        #1;
        @(posedge clk);
        #1;
        apply_reset();

        // Unconfigured: samples queue up, nothing is presented
        cycle(1, 4'd7, 1);
        cycle(1, 4'd8, 1);
        cycle(1, 4'd9, 1);
        repeat (3) cycle(0, 0, 1);
        chk("uncfg_out_valid", 32'(bus.out_valid), 32'd0);
        chk("uncfg_configured", 32'(configured), 32'd0);
        chk("uncfg_in_ready_3", 32'(bus.in_ready), 32'd1);
        cycle(1, 4'd10, 1);
        chk("uncfg_full", 32'(bus.in_ready), 32'd0);

        // Basic flow
        apply_reset();
        write_shadow(4'd1, 4'd2, 4'd3, 4'd4, 1);
        cycle(0, 0, 1, 0, 0, 0, 1);
        cycle(1, 4'd5, 1);
        cycle(0, 0, 1);
        chk("basic_valid", 32'(bus.out_valid), 32'd1);
        check_tuple("basic_tuple", 4'd5, 4'd1, 4'd2, 4'd3, 4'd4);
        repeat (2) cycle(0, 0, 1);

        // Backpressure with FIFO filling up
        for (int i = 0; i < 6; i++) cycle(1, 4'(i), 0);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        check_tuple("bp_frozen", 4'd0, 4'd1, 4'd2, 4'd3, 4'd4);
        repeat (7) cycle(0, 0, 1);

        // Commit while a tuple is stalled
        cycle(1, 4'd3, 0);
        cycle(0, 0, 0);
        write_shadow(4'd2, 4'd2, 4'd2, 4'd2, 0);
        cycle(1, 4'd9, 0, 0, 0, 0, 1);
        repeat (2) cycle(0, 0, 0);
        check_tuple("stall_held", 4'd3, 4'd1, 4'd2, 4'd3, 4'd4);
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        check_tuple("stall_new_coef", 4'd9, 4'd2, 4'd2, 4'd2, 4'd2);
        repeat (2) cycle(0, 0, 1);

        // Reset with work in flight
        for (int i = 0; i < 4; i++) cycle(1, 4'(11 + i), 0);
        cycle(0, 0, 0);
        chk("mid_valid_before", 32'(bus.out_valid), 32'd1);
        apply_reset();

        // Random traffic including commits and coefficient writes
        for (int n = 0; n < 500; n++) begin
            cycle(($urandom % 4) != 0, 4'($urandom), ($urandom % 3) != 0,
                  ($urandom % 4) == 0, 2'($urandom), 4'($urandom), ($urandom % 20) == 0);
        end
        repeat (10) cycle(0, 0, 1);

        // Handshake counting: 20 transfers, then a stalled tuple
        apply_reset();
        write_shadow(4'd3, 4'd1, 4'd4, 4'd1, 1);
        cycle(0, 0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) cycle(1, 4'(i), 1);
        repeat (2) cycle(0, 0, 1);
        cycle(1, 4'd6, 0);
        repeat (3) cycle(0, 0, 0);
        chk("cnt_stalled_valid", 32'(bus.out_valid), 32'd1);
`ifdef SOP_FEEDER_CNT_EN
        chk("cnt_twenty", 32'(tuple_cnt), 32'd20);
`endif
        repeat (2) cycle(0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sop_stream_feeder
